sent_crc_engine: RTL and testbench
==================================

SENT_CRC_ENGINE -- requirements
Module: sent_crc_engine

Interface
REQ-001 Parameter CRC4_SEED, 4'b0101, initial CRC4 register value.
REQ-002 Parameter CRC6_SEED, 6'b010101, initial CRC6 register value.
REQ-003 Parameter AUGMENT, 1, 1 = append zero augmentation after last nibble; 0 = no augmentation.
REQ-004 Parameter MAX_NIBBLES, 8, maximum data nibbles per message (range 1..255).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  begin message; loads seed and latches mode.
REQ-008 mode  in  1  sampled with start; 0 = CRC4, 1 = CRC6.
REQ-009 din  in  4  data nibble, MSB first.
REQ-010 din_valid  in  1  din is valid this cycle.
REQ-011 last  in  1  qualifies din_valid; marks final nibble.
REQ-012 chk_crc  in  6  received CRC, sampled on the last beat; CRC4 uses [3:0].
REQ-013 busy  out  1  high in ACCUM and AUG.
REQ-014 crc_valid  out  1  one-cycle result strobe.
REQ-015 crc_out  out  6  computed CRC; CRC4 in [3:0] with [5:4]=0.
REQ-016 crc_ok  out  1  crc_out equals masked chk_crc and err=0; valid with crc_valid.
REQ-017 err  out  1  nibble count exceeded MAX_NIBBLES; valid with crc_valid.

Function
REQ-018 Bit step, CRC4: new = {crc[2:0], b}; if old crc[3]=1, XOR new with 4'hD (x^4+x^3+x^2+1).
REQ-019 Bit step, CRC6: new = {crc[4:0], b}; if old crc[5]=1, XOR new with 6'h19 (x^6+x^4+x^3+1).
REQ-020 Each accepted nibble applies four bit steps, din[3] first, in one cycle.
REQ-021 FSM states: IDLE, ACCUM, AUG, DONE.
REQ-022 IDLE: start -> ACCUM, CRC loaded with the seed for the sampled mode, nibble count cleared; din_valid without start is ignored.
REQ-023 start with din_valid in the same cycle: the nibble is processed from the seed and counted.
REQ-024 ACCUM: each din_valid processes one nibble and increments the count, saturating at 255.
REQ-025 ACCUM, din_valid & last: -> AUG if AUGMENT=1, else -> DONE; chk_crc is latched.
REQ-026 last without din_valid is ignored.
REQ-027 AUG (one cycle): applies 4 zero bit steps (CRC4) or 6 zero bit steps (CRC6), then -> DONE.
REQ-028 DONE (one cycle): crc_valid=1; crc_out, crc_ok and err are driven; next state is IDLE.
REQ-029 Latency from last beat to crc_valid: 2 cycles with AUGMENT=1, 1 cycle with AUGMENT=0.
REQ-030 start in ACCUM aborts the message and reseeds, same as REQ-022/023; no crc_valid for the aborted message.
REQ-031 start in AUG is ignored; start in DONE is accepted (back-to-back messages) while crc_valid is still emitted.
REQ-032 din_valid in AUG or DONE without start is ignored.
REQ-033 err=1 if the count exceeds MAX_NIBBLES; the CRC still covers all nibbles; crc_ok is forced to 0.
REQ-034 crc_out, crc_ok and err hold their value until the next crc_valid.

Reset
REQ-035 reset forces IDLE with busy=0, crc_valid=0, crc_out=0, crc_ok=0, err=0, and count=0.
REQ-036 reset mid-message discards the message; no crc_valid follows.

Verification
REQ-037 CRC4, AUGMENT=1: start+mode=0, one nibble 0x0 with last, chk_crc=0x0A -> crc_valid 2 cycles later, crc_out=0x0A, crc_ok=1, err=0.
REQ-038 CRC6, AUGMENT=1: start+mode=1, one nibble 0x0 with last, chk_crc=0x1C -> crc_out=0x1C, crc_ok=1; with chk_crc=0x1D -> crc_ok=0.
REQ-039 CRC4, AUGMENT=0: nibble 0x0 with last -> crc_out=0x03 one cycle after the last beat.
REQ-040 MAX_NIBBLES=8: send 9 nibbles -> crc_valid with err=1 and crc_ok=0.
REQ-041 Abort and back-to-back: start, 3 nibbles, start again, single 0x0 last -> one crc_valid only, value 0x0A; then start during DONE -> the second message computes correctly.
REQ-042 Reset asserted during AUG -> all outputs 0 immediately, and no crc_valid after reset releases.

Source files
------------

// File: rtl/sent_crc_engine.sv
// SENT CRC engine: accumulates 4-bit data nibbles into a CRC4 or CRC6
// register, optionally appends zero augmentation, then reports the result
// once per message together with a compare against the received CRC.
//
// Handshake: a nibble is accepted on any rising edge where din_valid is high
// and either start is high (outside AUG) or the engine is in ACCUM; last is
// only meaningful on an accepted beat. crc_valid is a single-cycle strobe with
// no back-pressure; crc_out/crc_ok/err stay stable until the next strobe.
module sent_crc_engine #(
  parameter logic [3:0] CRC4_SEED   = 4'b0101,
  parameter logic [5:0] CRC6_SEED   = 6'b010101,
  parameter bit         AUGMENT     = 1'b1,
  parameter int         MAX_NIBBLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic [3:0] din,
  input  logic       din_valid,
  input  logic       last,
  input  logic [5:0] chk_crc,
  output logic       busy,
  output logic       crc_valid,
  output logic [5:0] crc_out,
  output logic       crc_ok,
  output logic       err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    AUG   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_NIBBLES);
  localparam state_t     FIN_ST  = AUGMENT ? AUG : DONE;

  state_t     state_q, state_d;
  logic [5:0] crc_q, crc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic [5:0] chk_q, chk_d;
  logic [5:0] res_q, res_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;

  logic       take_start;
  logic       accept;
  logic       fin_beat;

  // One shift of the selected CRC register; CRC4 lives in [3:0], [5:4] stay 0.
  function automatic logic [5:0] bit_step(input logic m, input logic [5:0] c,
                                          input logic b);
    logic [5:0] n;
    if (m) begin
      n = {c[4:0], b};
      if (c[5]) n = n ^ 6'h19;
    end else begin
      n = {2'b00, c[2:0], b};
      if (c[3]) n = n ^ 6'h0D;
    end
    return n;
  endfunction

  // Four bit steps, MSB of the nibble first.
  function automatic logic [5:0] nib_step(input logic m, input logic [5:0] c,
                                          input logic [3:0] d);
    logic [5:0] r;
    r = c;
    for (int i = 3; i >= 0; i--) r = bit_step(m, r, d[i]);
    return r;
  endfunction

  // Zero augmentation: one register width of zero bits.
  function automatic logic [5:0] aug_step(input logic m, input logic [5:0] c);
    logic [5:0] r;
    r = c;
    for (int i = 0; i < 6; i++) begin
      if (m || (i < 4)) r = bit_step(m, r, 1'b0);
    end
    return r;
  endfunction

  // Beat qualification: start is honoured everywhere except AUG.
  always_comb begin
    take_start = start && (state_q != AUG);
    accept     = din_valid && (take_start || (state_q == ACCUM));
    fin_beat   = accept && last;
  end

  // State register and datapath flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q   <= 6'd0;
      cnt_q   <= 8'd0;
      mode_q  <= 1'b0;
      chk_q   <= 6'd0;
      res_q   <= 6'd0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      chk_q   <= chk_d;
      res_q   <= res_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; a start that also carries the last beat is a complete
  // one-nibble message.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_start) state_d = fin_beat ? FIN_ST : ACCUM;
      ACCUM:   if (fin_beat) state_d = FIN_ST;
               else if (take_start) state_d = ACCUM;
      AUG:     state_d = DONE;
      DONE:    if (take_start) state_d = fin_beat ? FIN_ST : ACCUM;
               else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: reseed on start, fold accepted nibbles, augment, and capture
  // the result on the way into DONE so it is stable for the strobe cycle.
  always_comb begin
    mode_d = take_start ? mode : mode_q;
    crc_d  = take_start ? (mode ? CRC6_SEED : {2'b00, CRC4_SEED}) : crc_q;
    cnt_d  = take_start ? 8'd0 : cnt_q;
    chk_d  = chk_q;
    res_d  = res_q;
    ok_d   = ok_q;
    err_d  = err_q;
    if (accept) begin
      crc_d = nib_step(mode_d, crc_d, din);
      if (cnt_d != 8'hFF) cnt_d = cnt_d + 8'd1;
    end
    if (fin_beat) chk_d = mode_d ? chk_crc : {2'b00, chk_crc[3:0]};
    if (state_q == AUG) crc_d = aug_step(mode_q, crc_q);
    if (state_d == DONE) begin
      res_d = crc_d;
      err_d = cnt_d > MAX_CNT;
      ok_d  = (crc_d == chk_d) && !(cnt_d > MAX_CNT);
    end
  end

  // Output decode from the registered state and result.
  always_comb begin
    busy      = (state_q == ACCUM) || (state_q == AUG);
    crc_valid = (state_q == DONE);
    state_dbg = state_q;
    crc_out   = res_q;
    crc_ok    = ok_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_sent_crc_engine.sv
// Testbench for sent_crc_engine: table vectors with hand-derived results,
// hand-written multi-cycle sequences, and a randomized run scored against a
// polynomial-division reference model.
module tb_sent_crc_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] din = 4'h0;
  logic       din_valid = 1'b0;
  logic       last = 1'b0;
  logic [5:0] chk_crc = 6'h0;

  logic       busy, crc_valid, crc_ok, err;
  logic [5:0] crc_out;
  logic [1:0] state_dbg;
  logic       busy0, crc_valid0, crc_ok0, err0;
  logic [5:0] crc_out0;
  logic [1:0] state_dbg0;

  int         n_vec = 0;
  int         n_bad = 0;
  int         vcount = 0;
  bit         mon_en = 1'b0;
  logic [7:0] exp_q[$];   // {err, crc_ok, crc_out}
  logic [3:0] msg_q[$];
  logic [7:0] e_m;

  typedef struct {
    logic        mode;
    int          n;
    logic [35:0] data;
    logic [5:0]  chk;
    logic [5:0]  e_crc;
    logic        e_ok;
    logic        e_err;
  } vec_t;
  vec_t vecs[8];

  sent_crc_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .din(din),
    .din_valid(din_valid), .last(last), .chk_crc(chk_crc), .busy(busy),
    .crc_valid(crc_valid), .crc_out(crc_out), .crc_ok(crc_ok), .err(err),
    .state_dbg(state_dbg)
  );

  sent_crc_engine #(.AUGMENT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .din(din),
    .din_valid(din_valid), .last(last), .chk_crc(chk_crc), .busy(busy0),
    .crc_valid(crc_valid0), .crc_out(crc_out0), .crc_ok(crc_ok0), .err(err0),
    .state_dbg(state_dbg0)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: CRC as polynomial division of the message bit stream (plus
  // augmentation zeros) starting from the seed remainder.
  function automatic logic [7:0] model_result(input logic m, input logic [5:0] chk);
    int   w, poly, r;
    int   bits[$];
    logic e_err, ok;
    logic [5:0] masked;
    w    = m ? 6 : 4;
    poly = m ? 'h59 : 'h1D;
    r    = m ? 'h15 : 'h5;
    foreach (msg_q[i]) for (int b = 3; b >= 0; b--) bits.push_back(int'(msg_q[i][b]));
    for (int k = 0; k < w; k++) bits.push_back(0);
    foreach (bits[i]) begin
      r = (r << 1) | bits[i];
      if (r >= (1 << w)) r = r ^ poly;
    end
    e_err  = msg_q.size() > 8;
    masked = m ? chk : {2'b00, chk[3:0]};
    ok     = (6'(r) == masked) && !e_err;
    return {e_err, ok, 6'(r)};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (crc_valid) vcount++;
    if (mon_en && crc_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_crc_valid: got crc_out 0x%0h, expected no strobe", crc_out);
      end else begin
        e_m = exp_q.pop_front();
        check("rand_result", {24'h0, err, crc_ok, crc_out}, {24'h0, e_m});
      end
    end
  end

  task automatic drive(input logic s, input logic m, input logic dv, input logic l,
                       input logic [3:0] d, input logic [5:0] c);
    start = s; mode = m; din_valid = dv; last = l; din = d; chk_crc = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 6'h0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!crc_valid && lat < 8) begin
      idle_cycle();
      lat++;
    end
  endtask

  initial begin
    vec_t v;
    int   lat, v0, g;
    logic m, abort, comb, c_good, lastb;
    int   n, n_send;
    logic [7:0] tmp;
    logic [5:0] chk;

    vecs[0] = '{1'b0, 1, 36'h0,           6'h0A, 6'h0A, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1, 36'h0,           6'h1C, 6'h1C, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1, 36'h0,           6'h1D, 6'h1C, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1, 36'h0,           6'h2A, 6'h0A, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1, 36'hF_0000_0000, 6'h0F, 6'h0F, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1, 36'hF_0000_0000, 6'h0E, 6'h0F, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8, 36'h0,           6'h0A, 6'h0A, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 9, 36'h0,           6'h06, 6'h06, 1'b0, 1'b1};

    // Reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", crc_valid, 0);
    check("rst_crc", crc_out, 0);
    check("rst_ok", crc_ok, 0);
    check("rst_err", err, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;
    idle_cycle();

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      drive(1'b1, v.mode, 1'b0, 1'b0, 4'h0, 6'h0);
      for (int k = 0; k < v.n; k++)
        drive(1'b0, v.mode, 1'b1, k == v.n - 1, v.data[35 - 4*k -: 4], v.chk);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_crc", i), crc_out, v.e_crc);
      check($sformatf("vec%0d_ok", i), crc_ok, v.e_ok);
      check($sformatf("vec%0d_err", i), err, v.e_err);
      idle_cycle();
      check($sformatf("vec%0d_strobe_len", i), crc_valid, 0);
      check($sformatf("vec%0d_hold", i), crc_out, v.e_crc);
    end

    // Reset while in AUG: outputs clear at once, the message is lost
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 6'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 6'h0A);
    check("aug_busy", busy, 1);
    v0 = vcount;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", crc_valid, 0);
    check("mid_rst_crc", crc_out, 0);
    check("mid_rst_ok", crc_ok, 0);
    check("mid_rst_err", err, 0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (5) idle_cycle();
    check("mid_rst_no_strobe", vcount - v0, 0);

    // Start and last in one beat; AUGMENT=0 instance reports one cycle earlier
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 6'h0A);
    check("noaug_valid", crc_valid0, 1);
    check("noaug_crc", crc_out0, 6'h03);
    check("noaug_ok", crc_ok0, 0);
    check("aug_not_yet", crc_valid, 0);
    idle_cycle();
    check("combo_valid", crc_valid, 1);
    check("combo_crc", crc_out, 6'h0A);
    check("combo_ok", crc_ok, 1);
    idle_cycle();

    // Abort mid-message, then back-to-back start during DONE
    v0 = vcount;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 6'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 6'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 6'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 6'h0);
    check("accum_busy", busy, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 6'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 6'h0A);
    idle_cycle();
    check("abort_valid", crc_valid, 1);
    check("abort_crc", crc_out, 6'h0A);
    check("abort_ok", crc_ok, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 6'h1C);
    idle_cycle();
    check("b2b_valid", crc_valid, 1);
    check("b2b_crc", crc_out, 6'h1C);
    check("b2b_ok", crc_ok, 1);
    idle_cycle();
    check("abort_strobe_count", vcount - v0, 2);

    // Start during AUG is ignored
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 6'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 6'h1C);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 6'h0F);
    check("augstart_valid", crc_valid, 1);
    check("augstart_crc", crc_out, 6'h1C);
    check("augstart_ok", crc_ok, 1);
    idle_cycle();
    check("augstart_idle_busy", busy, 0);
    v0 = vcount;
    repeat (3) idle_cycle();
    check("augstart_no_strobe", vcount - v0, 0);

    // Randomized messages against the reference model
    mon_en = 1'b1;
    for (int t = 0; t < 60; t++) begin
      m      = 1'($urandom_range(0, 1));
      n      = $urandom_range(1, 10);
      abort  = ($urandom_range(0, 9) == 0);
      c_good = 1'($urandom_range(0, 1));
      msg_q.delete();
      for (int k = 0; k < n; k++) msg_q.push_back(4'($urandom_range(0, 15)));
      n_send = abort ? $urandom_range(0, n - 1) : n;
      comb   = (n_send > 0) && ($urandom_range(0, 1) == 1);
      tmp    = model_result(m, 6'h0);
      if (c_good) chk = m ? tmp[5:0] : {2'($urandom_range(0, 3)), tmp[3:0]};
      else        chk = 6'($urandom_range(0, 63));
      if (!comb) drive(1'b1, m, 1'b0, 1'b0, 4'($urandom_range(0, 15)), 6'h0);
      for (int k = 0; k < n_send; k++) begin
        if (!(comb && k == 0))
          repeat ($urandom_range(0, 2))
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
        lastb = !abort && (k == n_send - 1);
        if (lastb) exp_q.push_back(model_result(m, chk));
        drive(comb && (k == 0), m, 1'b1, lastb, msg_q[k],
              lastb ? chk : 6'($urandom_range(0, 63)));
      end
      if (!abort) repeat ($urandom_range(1, 3)) idle_cycle();
      else        repeat ($urandom_range(0, 2)) idle_cycle();
    end
    g = 0;
    while (exp_q.size() != 0 && g < 20) begin
      idle_cycle();
      g++;
    end
    check("rand_drain", exp_q.size(), 0);
    mon_en = 1'b0;

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
